// File: rtl/rst_release_seq_if.sv
// Handshake bundle for the reset-release sequencer: ready/rearm in, reset and status out.
interface rst_release_seq_if;
    logic       ready;
    logic       rearm;
    logic       rst_out;
    logic       rst_fell;
    logic [1:0] state;
    logic       timeout_err;

    modport master (
        output ready,
        output rearm,
        input  rst_out,
        input  rst_fell,
        input  state,
        input  timeout_err
    );

    modport slave (
        input  ready,
        input  rearm,
        output rst_out,
        output rst_fell,
        output state,
        output timeout_err
    );
endinterface

// File: rtl/rst_release_seq.sv
// Reset-release sequencer: holds rst_out high until a synchronized ready is seen after MIN_HOLD.
// Define STRONG_UNTIL_EN for strong-until semantics (WAIT times out into a sticky ERR state).
module rst_release_seq #(
    parameter int unsigned MIN_HOLD    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input logic              clk,
    input logic              rst_n,
    rst_release_seq_if.slave bus
);
    localparam int unsigned MaxCnt = (MIN_HOLD > TIMEOUT) ? MIN_HOLD : TIMEOUT;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

    typedef enum logic [1:0] {
        StHold = 2'd0,
        StWait = 2'd1,
        StRun  = 2'd2,
        StErr  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ready_sync;
    logic                   rst_out_q;
    logic                   rst_fell_q;

    assign ready_sync = sync_q[SYNC_STAGES-1];

    // rearm wins over both ready and timeout
    always_comb begin
        state_d = state_q;
        if (bus.rearm) begin
            state_d = StHold;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (cnt_q == CntW'(MIN_HOLD - 1)) state_d = StWait;
                end
                StWait: begin
                    if (ready_sync) begin
                        state_d = StRun;
                    end
`ifdef STRONG_UNTIL_EN
                    else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_d = StErr;
                    end
`endif
                end
                StRun:   state_d = StRun;
                StErr:   state_d = StErr;
                default: state_d = StHold;
            endcase
        end
    end

    // Counter restarts on any state change or rearm and saturates instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (bus.rearm || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q != {CntW{1'b1}}) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

`ifdef STRONG_UNTIL_EN
    logic timeout_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StHold;
            cnt_q         <= '0;
            sync_q        <= '0;
            rst_out_q     <= 1'b1;
            rst_fell_q    <= 1'b0;
`ifdef STRONG_UNTIL_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.ready};
            rst_out_q     <= (state_d != StRun);
            rst_fell_q    <= (state_d == StRun) && (state_q != StRun);
`ifdef STRONG_UNTIL_EN
            timeout_err_q <= (state_d == StErr);
`endif
        end
    end

    assign bus.rst_out  = rst_out_q;
    assign bus.rst_fell = rst_fell_q;
    assign bus.state    = state_q;
`ifdef STRONG_UNTIL_EN
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_rst_release_seq.sv
// Scoreboard bench for rst_release_seq: stimulus queues expected snapshots, a negedge monitor checks.
module tb_rst_release_seq;
    localparam int unsigned MinHold    = 4;
    localparam int unsigned SyncStages = 2;
    localparam int unsigned Timeout    = 16;
    localparam logic [1:0]  SHold      = 2'd0;
    localparam logic [1:0]  SWait      = 2'd1;
    localparam logic [1:0]  SRun       = 2'd2;
    localparam logic [1:0]  SErr       = 2'd3;
`ifdef STRONG_UNTIL_EN
    localparam int LowCyc = 12;
`else
    localparam int LowCyc = 20;
`endif

    typedef struct {
        int         t;
        logic       ro;
        logic [1:0] st;
        logic       rf;
        logic       te;
        string      nm;
    } exp_t;

    logic   clk;
    logic   rst_n;
    exp_t   exp_q[$];
    int     fell_q[$];
    int     tick  = 0;
    int     total = 0;
    int     bad   = 0;
    logic   done  = 1'b0;

    rst_release_seq_if bus ();

    rst_release_seq #(
        .MIN_HOLD   (MinHold),
        .SYNC_STAGES(SyncStages),
        .TIMEOUT    (Timeout)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    task automatic expect_at(input int dt, input logic ro, input logic [1:0] st, input logic rf,
                             input logic te, input string nm);
        exp_t e;
        e.t  = tick + dt;
        e.ro = ro;
        e.st = st;
        e.rf = rf;
        e.te = te;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: sole owner of the counters
    always @(negedge clk) begin
        int f;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].t <= tick) begin
                total++;
                if (exp_q[i].t < tick) begin
                    bad++;
                    $display("FAIL %s: sample for tick %0d missed (now %0d)", exp_q[i].nm,
                             exp_q[i].t, tick);
                end else if ({bus.rst_out, bus.state, bus.rst_fell, bus.timeout_err} !==
                             {exp_q[i].ro, exp_q[i].st, exp_q[i].rf, exp_q[i].te}) begin
                    bad++;
                    $display("FAIL %s tick %0d: got rst_out=%b state=%0d fell=%b terr=%b, want rst_out=%b state=%0d fell=%b terr=%b",
                             exp_q[i].nm, tick, bus.rst_out, bus.state, bus.rst_fell,
                             bus.timeout_err, exp_q[i].ro, exp_q[i].st, exp_q[i].rf, exp_q[i].te);
                end
                exp_q.delete(i);
            end
        end
        if (bus.rst_fell === 1'b1) begin
            total++;
            if (fell_q.size() == 0) begin
                bad++;
                $display("FAIL rst_fell_pulse: unexpected pulse at tick %0d, none queued", tick);
            end else begin
                f = fell_q.pop_front();
                if (f != tick) begin
                    bad++;
                    $display("FAIL rst_fell_pulse: got pulse at tick %0d, want tick %0d", tick, f);
                end
            end
        end
        if (done) begin
            total++;
            if (exp_q.size() != 0 || fell_q.size() != 0) begin
                bad++;
                $display("FAIL drain: got %0d samples and %0d pulses outstanding, want 0 and 0",
                         exp_q.size(), fell_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        int t0;
        rst_n     = 1'b0;
        bus.ready = 1'b1;
        bus.rearm = 1'b0;

        // 1: release with ready steady high
        step(3);
        expect_at(0, 1'b1, SHold, 1'b0, 1'b0, "reset_state");
        step(1);
        rst_n = 1'b1;
        expect_at(1, 1'b1, SHold, 1'b0, 1'b0, "t1_edge1");
        expect_at(3, 1'b1, SHold, 1'b0, 1'b0, "t1_edge3");
        expect_at(4, 1'b1, SWait, 1'b0, 1'b0, "t1_edge4_wait");
        expect_at(5, 1'b0, SRun,  1'b1, 1'b0, "t1_edge5_fall");
        expect_at(6, 1'b0, SRun,  1'b0, 1'b0, "t1_edge6_run");
        fell_q.push_back(tick + 5);
        step(6);

        // 2: ready low for LowCyc cycles after a rearm, then high
        bus.ready = 1'b0;
        bus.rearm = 1'b1;
        expect_at(1, 1'b1, SHold, 1'b0, 1'b0, "t2_rearm_hold");
        expect_at(5, 1'b1, SWait, 1'b0, 1'b0, "t2_wait");
        expect_at(LowCyc, 1'b1, SWait, 1'b0, 1'b0, "t2_ready_low");
        expect_at(LowCyc + 2, 1'b1, SWait, 1'b0, 1'b0, "t2_sync_delay");
        expect_at(LowCyc + 3, 1'b0, SRun, 1'b1, 1'b0, "t2_fall");
        fell_q.push_back(tick + LowCyc + 3);
        step(1);
        bus.rearm = 1'b0;
        step(LowCyc - 1);
        bus.ready = 1'b1;
        step(4);

        // 3: ready glitches in RUN are ignored
        bus.ready = 1'b0;
        for (int k = 2; k <= 8; k += 2) expect_at(k, 1'b0, SRun, 1'b0, 1'b0, "t3_run_hold");
        step(3);
        bus.ready = 1'b1;
        step(5);

        // 4: rearm from RUN with ready high
        bus.rearm = 1'b1;
        expect_at(1, 1'b1, SHold, 1'b0, 1'b0, "t4_rearm_hold");
        expect_at(4, 1'b1, SHold, 1'b0, 1'b0, "t4_still_hold");
        expect_at(5, 1'b1, SWait, 1'b0, 1'b0, "t4_wait");
        expect_at(6, 1'b0, SRun,  1'b1, 1'b0, "t4_fall");
        fell_q.push_back(tick + 6);
        step(1);
        bus.rearm = 1'b0;
        step(7);

        // 4b: rearm beats ready_sync in WAIT
        bus.rearm = 1'b1;
        expect_at(5,  1'b1, SWait, 1'b0, 1'b0, "t4b_wait");
        expect_at(6,  1'b1, SHold, 1'b0, 1'b0, "t4b_rearm_prio");
        expect_at(10, 1'b1, SWait, 1'b0, 1'b0, "t4b_wait2");
        expect_at(11, 1'b0, SRun,  1'b1, 1'b0, "t4b_fall");
        fell_q.push_back(tick + 11);
        step(1);
        bus.rearm = 1'b0;
        step(4);
        bus.rearm = 1'b1;
        step(1);
        bus.rearm = 1'b0;
        step(6);

        // 5: ready never arrives
        bus.ready = 1'b0;
        bus.rearm = 1'b1;
`ifdef STRONG_UNTIL_EN
        expect_at(5,  1'b1, SWait, 1'b0, 1'b0, "t5_wait");
        expect_at(20, 1'b1, SWait, 1'b0, 1'b0, "t5_before_timeout");
        expect_at(21, 1'b1, SErr,  1'b0, 1'b1, "t5_timeout");
        expect_at(30, 1'b1, SErr,  1'b0, 1'b1, "t5_late_ready");
        expect_at(31, 1'b1, SHold, 1'b0, 1'b0, "t5_rearm_clear");
        expect_at(35, 1'b1, SWait, 1'b0, 1'b0, "t5_rewait");
        expect_at(36, 1'b0, SRun,  1'b1, 1'b0, "t5_fall");
        fell_q.push_back(tick + 36);
        step(1);
        bus.rearm = 1'b0;
        step(24);
        bus.ready = 1'b1;
        step(5);
        bus.rearm = 1'b1;
        step(1);
        bus.rearm = 1'b0;
        step(6);
`else
        for (int k = 5; k <= 205; k += 25) expect_at(k, 1'b1, SWait, 1'b0, 1'b0, "t5_weak_wait");
        expect_at(208, 1'b0, SRun, 1'b1, 1'b0, "t5_weak_fall");
        fell_q.push_back(tick + 208);
        step(1);
        bus.rearm = 1'b0;
        step(204);
        bus.ready = 1'b1;
        step(4);
`endif

        // 6: asynchronous reset between edges while in RUN
        expect_at(0, 1'b1, SHold, 1'b0, 1'b0, "t6_async_reset");
        expect_at(1, 1'b1, SHold, 1'b0, 1'b0, "t6_reset_held");
        #1;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        t0 = tick;
        expect_at(4, 1'b1, SWait, 1'b0, 1'b0, "t6_wait");
        expect_at(5, 1'b0, SRun,  1'b1, 1'b0, "t6_fall");
        fell_q.push_back(t0 + 5);
        step(7);
        done = 1'b1;
    end
endmodule
